// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared core memory-port definitions
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int MEM_ADDR_W = 64;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_MASK_W = MEM_DATA_W / 8;
endpackage

// File: rtl/mem_port_arbiter_rr.sv
// rr_arbiter2: two-input round-robin grant, favouring whoever was not served last
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic rr_last,
  output logic gnt_valid,
  output logic gnt_id
);
  always_comb begin
    gnt_valid = req_ifu || req_lsu;
    gnt_id    = (req_ifu && req_lsu) ? ~rr_last : (req_lsu ? REQ_LSU : REQ_IFU);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IFU and LSU, one transaction in flight
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_resp_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_resp_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  output logic                timeout_flag
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  state_t        state;
  logic          owner, rr_last, gnt_valid, gnt_id;
  logic          accept, busy, done, expire, resp_fire;
  logic [CW-1:0] cnt;
  rr_arbiter2 u_rr (
    .req_ifu   (ifu_req_valid),
    .req_lsu   (lsu_req_valid),
    .rr_last   (rr_last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );
  // A completing handshake in the expiry cycle beats the watchdog.
  always_comb begin
    accept         = rst && state == IDLE && gnt_valid;
    busy           = rst && state != IDLE;
    done           = (state == REQ && mem_req_ready) || (state == RESP && mem_resp_valid);
    expire         = busy && TIMEOUT != 0 && cnt >= CW'(TIMEOUT - 1) && !done;
    resp_fire      = rst && state == RESP && mem_resp_valid;
    ifu_req_ready  = accept && gnt_id == REQ_IFU;
    lsu_req_ready  = accept && gnt_id == REQ_LSU;
    mem_req_valid  = rst && state == REQ;
    ifu_resp_valid = (resp_fire || expire) && owner == REQ_IFU;
    lsu_resp_valid = (resp_fire || expire) && owner == REQ_LSU;
    ifu_resp_err   = expire && owner == REQ_IFU;
    lsu_resp_err   = expire && owner == REQ_LSU;
    ifu_resp_rdata = (resp_fire && owner == REQ_IFU) ? mem_resp_rdata : '0;
    lsu_resp_rdata = (resp_fire && owner == REQ_LSU && !mem_req_wen) ? mem_resp_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= REQ_IFU;
      rr_last       <= REQ_IFU;
      cnt           <= '0;
      timeout_flag  <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
    end else begin
      cnt <= accept ? '0 : busy ? cnt + CW'(1) : cnt;
      if (expire) timeout_flag <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          owner         <= gnt_id;
          rr_last       <= gnt_id;
          mem_req_addr  <= (gnt_id == REQ_LSU) ? lsu_req_addr : ifu_req_addr;
          mem_req_wen   <= (gnt_id == REQ_LSU) && lsu_req_wen;
          mem_req_wdata <= (gnt_id == REQ_LSU) ? lsu_req_wdata : '0;
          mem_req_wmask <= (gnt_id == REQ_LSU) ? lsu_req_wmask : '0;
          state         <= REQ;
        end
        REQ:     state <= expire ? IDLE : mem_req_ready ? RESP : REQ;
        RESP:    state <= (expire || mem_resp_valid) ? IDLE : RESP;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic        clk = 0, rst = 0;
  logic        ifu_req_valid = 0, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [63:0] ifu_req_addr = 0, ifu_resp_rdata;
  logic        lsu_req_valid = 0, lsu_req_ready, lsu_req_wen = 0, lsu_resp_valid, lsu_resp_err;
  logic [63:0] lsu_req_addr = 0, lsu_req_wdata = 0, lsu_resp_rdata;
  logic [7:0]  lsu_req_wmask = 0, mem_req_wmask;
  logic        mem_req_valid, mem_req_ready = 0, mem_req_wen, mem_resp_valid = 0, timeout_flag;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_rdata = 0;
  typedef struct {logic lsu; logic [63:0] rdata; logic err;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, passes = 0;
  logic lf;

  mem_port_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic lsu, input logic [63:0] rdata, input logic err);
    exp_t e;
    e.lsu = lsu; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  // Full transaction: request, wait_cycles of stalled mem_req_ready, then a response.
  task automatic xact(input logic lsu, input logic [63:0] addr, input logic wen,
                      input logic [63:0] wdata, input logic [7:0] wmask,
                      input int wait_cycles, input logic [63:0] rdata);
    if (lsu) begin
      lsu_req_valid = 1; lsu_req_addr = addr; lsu_req_wen = wen;
      lsu_req_wdata = wdata; lsu_req_wmask = wmask;
    end else begin
      ifu_req_valid = 1; ifu_req_addr = addr;
    end
    #1 chk("req_ready", {ifu_req_ready, lsu_req_ready}, lsu ? 2'b01 : 2'b10);
    tick();
    ifu_req_valid = 0; lsu_req_valid = 0;
    ifu_req_addr = ~addr; lsu_req_addr = ~addr; lsu_req_wdata = ~wdata; lsu_req_wmask = ~wmask;
    for (int i = 0; i <= wait_cycles; i++) begin
      mem_req_ready = (i == wait_cycles);
      #1;
      chk("mem_req_valid", mem_req_valid, 1);
      chk("mem_req_addr", mem_req_addr, addr);
      chk("mem_req_wen", mem_req_wen, lsu & wen);
      chk("mem_req_wdata", mem_req_wdata, lsu ? wdata : 64'h0);
      chk("mem_req_wmask", mem_req_wmask, lsu ? wmask : 8'h0);
      chk("ready_busy", {ifu_req_ready, lsu_req_ready}, 0);
      tick();
    end
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = rdata;
    push(lsu, (lsu && wen) ? 64'h0 : rdata, 1'b0);
    #1 chk("resp_valid", {ifu_resp_valid, lsu_resp_valid}, lsu ? 2'b01 : 2'b10);
    tick();
    mem_resp_valid = 0;
  endtask

  always @(negedge clk) begin
    if (ifu_resp_valid || lsu_resp_valid) begin
      chk("resp_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("resp_owner", {ifu_resp_valid, lsu_resp_valid}, mon_e.lsu ? 2'b01 : 2'b10);
        chk("resp_rdata", mon_e.lsu ? lsu_resp_rdata : ifu_resp_rdata, mon_e.rdata);
        chk("resp_err", mon_e.lsu ? lsu_resp_err : ifu_resp_err, mon_e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    ifu_req_valid = 1; ifu_req_addr = 64'h8000_0000;
    lsu_req_valid = 1; lsu_req_addr = 64'h8000_3000; lsu_req_wmask = 8'hFF;
    tick(); tick();
    chk("rst_ready", {ifu_req_ready, lsu_req_ready}, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_resp", {ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err}, 0);
    chk("rst_flag", timeout_flag, 0);
    chk("rst_addr", mem_req_addr, 0);
    rst = 1;
    // Both requesters held from reset: grants alternate starting with LSU.
    for (int i = 0; i < 4; i++) begin
      lf = (i % 2 == 0);
      #1 chk("rr_grant", {ifu_req_ready, lsu_req_ready}, lf ? 2'b01 : 2'b10);
      tick();
      mem_req_ready = 1;
      #1 chk("rr_addr", mem_req_addr, lf ? 64'h8000_3000 : 64'h8000_0000);
      chk("rr_ready_busy", {ifu_req_ready, lsu_req_ready}, 0);
      tick();
      mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 64'h1000 + 64'(i);
      push(lf, 64'h1000 + 64'(i), 1'b0);
      if (i == 3) begin ifu_req_valid = 0; lsu_req_valid = 0; end
      tick();
      mem_resp_valid = 0;
    end
    xact(1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h0, 0, 64'h0010_0073);
    xact(1'b1, 64'h8000_1000, 1'b1, 64'h1234_5678_8765_4321, 8'hFF, 3, 64'hBAD);
    xact(1'b1, 64'h8000_2000, 1'b0, 64'h0, 8'h0F, 6, 64'hCAFE_F00D);
    chk("flag_after_late_done", timeout_flag, 0);
    ifu_req_valid = 1; ifu_req_addr = 64'h8000_4000;
    #1 chk("to_ready", ifu_req_ready, 1);
    tick();
    ifu_req_valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push(1'b0, 64'h0, 1'b1);
      #1 chk("to_req_valid", mem_req_valid, 1);
      if (i == 7) chk("to_err", ifu_resp_err, 1);
      tick();
    end
    chk("to_idle", mem_req_valid, 0);
    chk("to_flag", timeout_flag, 1);
    xact(1'b1, 64'h8000_5000, 1'b0, 64'h0, 8'hFF, 1, 64'h5555_AAAA);
    chk("flag_sticky", timeout_flag, 1);
    ifu_req_valid = 1; ifu_req_addr = 64'h8000_6000;
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    #1 chk("mid_req", mem_req_valid, 1);
    tick();
    mem_req_ready = 0; rst = 0;
    #1 chk("mid_rst_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    tick();
    rst = 1; mem_resp_valid = 1; mem_resp_rdata = 64'hDEAD_BEEF;
    #1 chk("post_rst_mem_valid", mem_req_valid, 0);
    chk("post_rst_flag", timeout_flag, 0);
    chk("stray_resp", {ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready}, 0);
    tick();
    mem_resp_valid = 0;
    xact(1'b0, 64'h8000_7000, 1'b0, 64'h0, 8'h0, 0, 64'h7777);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
